sr_simd_alu: RTL and testbench

SR_SIMD_ALU -- requirements
Module: sr_simd_alu

---
 rtl/sr_simd_alu.sv | 157 +++++++++++++++
 tb/tb_sr_simd_alu.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_simd_alu.sv
// Multi-cycle packed-SIMD saturating ALU: KADD/KSUB/KSLL/KSRA over LANE_W lanes,
// LANES_PER_CYC lanes per BUSY cycle, with per-op overflow and a sticky vxsat flag.
module sr_simd_alu #(
  parameter int XLEN          = 32,
  parameter int LANE_W        = 8,
  parameter int LANES_PER_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic [1:0]      oper,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            ov,
  output logic            vxsat,
  input  logic            vxsat_clr
);

  localparam int L    = XLEN / LANE_W;
  localparam int SHW  = $clog2(LANE_W);
  localparam int IDXW = $clog2(L + 1);
  localparam int WW   = 2 * LANE_W;

  localparam logic signed [WW-1:0] SAT_MAX = {{(LANE_W+1){1'b0}}, {(LANE_W-1){1'b1}}};
  localparam logic signed [WW-1:0] SAT_MIN = {{(LANE_W+1){1'b1}}, {(LANE_W-1){1'b0}}};

  if (LANES_PER_CYC < 1 || !(LANE_W == 8 || LANE_W == 16 || LANE_W == 32) ||
      (XLEN % (LANE_W * LANES_PER_CYC)) != 0) begin : g_param_chk
    $error("sr_simd_alu: illegal XLEN/LANE_W/LANES_PER_CYC combination");
  end

  localparam logic [1:0] OP_KADD = 2'b00;
  localparam logic [1:0] OP_KSUB = 2'b01;
  localparam logic [1:0] OP_KSLL = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              ov_q, ov_d;
  logic              vxsat_q, vxsat_d;
  logic [XLEN-1:0]   a_q, b_q;
  logic [1:0]        op_q;
  logic              accept, last;

  // Clamp a wide signed lane value into LANE_W bits; MSB of the return flags a clamp.
  function automatic logic [LANE_W:0] saturate(input logic signed [WW-1:0] v);
    if (v > SAT_MAX) return {1'b1, SAT_MAX[LANE_W-1:0]};
    if (v < SAT_MIN) return {1'b1, SAT_MIN[LANE_W-1:0]};
    return {1'b0, v[LANE_W-1:0]};
  endfunction

  // All ops are evaluated at 2*LANE_W bits, which holds every sum, difference and shift.
  function automatic logic [LANE_W:0] lane_op(input logic [LANE_W-1:0] a,
                                              input logic [LANE_W-1:0] b,
                                              input logic [1:0]        op,
                                              input logic [SHW-1:0]    sh);
    logic signed [WW-1:0] ea, eb, wide;
    ea = {{LANE_W{a[LANE_W-1]}}, a};
    eb = {{LANE_W{b[LANE_W-1]}}, b};
    case (op)
      OP_KADD: wide = ea + eb;
      OP_KSUB: wide = ea - eb;
      OP_KSLL: wide = ea <<< sh;
      default: wide = ea >>> sh;
    endcase
    return saturate(wide);
  endfunction

  assign accept = (state_q == S_IDLE) && in_valid;
  assign last   = (state_q == S_BUSY) && ((int'(idx_q) + LANES_PER_CYC) >= L);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_BUSY;
      S_BUSY:  if (last)      state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Lane datapath: a slice of lanes per BUSY cycle, overflow accumulated across slices
  always_comb begin
    logic [LANE_W:0] lane_r;
    int              lane;
    idx_d  = idx_q;
    res_d  = res_q;
    ov_d   = ov_q;
    lane_r = '0;
    lane   = 0;
    if (accept) begin
      idx_d = '0;
      ov_d  = 1'b0;
    end else if (state_q == S_BUSY) begin
      for (int k = 0; k < LANES_PER_CYC; k++) begin
        lane   = int'(idx_q) + k;
        lane_r = lane_op(a_q[lane*LANE_W +: LANE_W], b_q[lane*LANE_W +: LANE_W],
                         op_q, b_q[SHW-1:0]);
        res_d[lane*LANE_W +: LANE_W] = lane_r[LANE_W-1:0];
        ov_d = ov_d | lane_r[LANE_W];
      end
      idx_d = idx_q + IDXW'(LANES_PER_CYC);
    end
  end

  // Sticky flag: a set on the DONE-entry edge beats a simultaneous clear
  always_comb begin
    vxsat_d = vxsat_q;
    if (last && ov_d)   vxsat_d = 1'b1;
    else if (vxsat_clr) vxsat_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      res_q   <= '0;
      ov_q    <= 1'b0;
      vxsat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
      vxsat_q <= vxsat_d;
    end
  end

  // Operand capture needs no reset; it is only read after an accept
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= srcA;
      b_q  <= srcB;
      op_q <= oper;
    end
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  assign result = res_q;
  assign zero   = (res_q == '0);
  assign ov     = ov_q;
  assign vxsat  = vxsat_q;

endmodule

// File: tb/tb_sr_simd_alu.sv
// Bench for sr_simd_alu: default, 16-bit-lane and 4-lanes-per-cycle instances,
// table vectors plus a reference model, with a queue of expected results.
module tb_sr_simd_alu;

  localparam int ND = 3;
  localparam logic [1:0] KADD = 2'b00, KSUB = 2'b01, KSLL = 2'b10, KSRA = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid [ND];
  logic        in_ready [ND];
  logic [31:0] srcA     [ND];
  logic [31:0] srcB     [ND];
  logic [1:0]  oper     [ND];
  logic        out_valid[ND];
  logic        out_ready[ND];
  logic [31:0] result   [ND];
  logic        zero     [ND];
  logic        ov       [ND];
  logic        vxsat    [ND];
  logic        vxsat_clr[ND];

  always #5 clk = ~clk;

  sr_simd_alu u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .srcA(srcA[0]), .srcB(srcB[0]), .oper(oper[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .result(result[0]), .zero(zero[0]), .ov(ov[0]),
    .vxsat(vxsat[0]), .vxsat_clr(vxsat_clr[0]));

  sr_simd_alu #(.LANE_W(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .srcA(srcA[1]), .srcB(srcB[1]), .oper(oper[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .result(result[1]), .zero(zero[1]), .ov(ov[1]),
    .vxsat(vxsat[1]), .vxsat_clr(vxsat_clr[1]));

  sr_simd_alu #(.LANES_PER_CYC(4)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .srcA(srcA[2]), .srcB(srcB[2]), .oper(oper[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .result(result[2]), .zero(zero[2]), .ov(ov[2]),
    .vxsat(vxsat[2]), .vxsat_clr(vxsat_clr[2]));

  typedef struct { int dut; logic [31:0] res; logic ovf; } exp_t;
  typedef struct { logic [1:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] res; logic ovf; } vec_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic vx_exp[ND];
  int   lat_exp[ND] = '{4, 2, 1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, expv);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic expv);
    chk(nm, {31'b0, act}, {31'b0, expv});
  endtask

  // Independent integer model for 8-bit lanes
  function automatic void model8(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic o);
    int x, y, v, sh;
    r  = '0;
    o  = 1'b0;
    sh = int'(b[2:0]);
    for (int i = 0; i < 4; i++) begin
      x = int'($signed(a[i*8 +: 8]));
      y = int'($signed(b[i*8 +: 8]));
      case (op)
        KADD:    v = x + y;
        KSUB:    v = x - y;
        KSLL:    v = x * (1 << sh);
        default: v = x >>> sh;
      endcase
      if (v > 127)       begin v = 127;  o = 1'b1; end
      else if (v < -128) begin v = -128; o = 1'b1; end
      r[i*8 +: 8] = 8'(v);
    end
  endfunction

  task automatic issue(input int d, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic eov);
    exp_t e;
    int   g = 0;
    while (!in_ready[d] && g < 50) begin tick(); g++; end
    chk1("in_ready_pre_issue", in_ready[d], 1'b1);
    srcA[d] = a; srcB[d] = b; oper[d] = op; in_valid[d] = 1'b1;
    e.dut = d; e.res = er; e.ovf = eov;
    sb.push_back(e);
    tick();
    in_valid[d] = 1'b0;
    srcA[d] = $urandom(); srcB[d] = $urandom(); oper[d] = 2'($urandom_range(0, 3));
  endtask

  task automatic collect(input int d, input int elat, input int hold, input string nm);
    int   lat = 0;
    exp_t e;
    while (!out_valid[d] && lat < 50) begin tick(); lat++; end
    chk({nm, "_latency"}, 32'(lat), 32'(elat));
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s_scoreboard actual=empty expected=entry", nm);
      return;
    end
    e = sb.pop_front();
    vx_exp[d] = vx_exp[d] | e.ovf;
    chk({nm, "_result"}, result[d], e.res);
    chk1({nm, "_ov"}, ov[d], e.ovf);
    chk1({nm, "_zero"}, zero[d], e.res == 32'h0);
    chk1({nm, "_vxsat"}, vxsat[d], vx_exp[d]);
    for (int i = 0; i < hold; i++) begin
      in_valid[d] = 1'b1;
      srcA[d] = $urandom();
      tick();
      chk({nm, "_hold_result"}, result[d], e.res);
      chk1({nm, "_hold_in_ready"}, in_ready[d], 1'b0);
      chk1({nm, "_hold_out_valid"}, out_valid[d], 1'b1);
    end
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    chk1({nm, "_post_in_ready"}, in_ready[d], 1'b1);
    chk1({nm, "_post_out_valid"}, out_valid[d], 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[$];
    logic [31:0] ra, rb, rr;
    logic [1:0]  rop;
    logic        ro;
    logic        seen;

    vt = '{
      '{KSLL, 32'h7F01C002, 32'h00000002, 32'h7F048008, 1'b1},
      '{KADD, 32'h7F7F8080, 32'h01FF80FF, 32'h7F7E8080, 1'b1},
      '{KSUB, 32'h05050505, 32'h01020304, 32'h04030201, 1'b0},
      '{KSUB, 32'h80000000, 32'h01000000, 32'h80000000, 1'b1},
      '{KADD, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0},
      '{KSRA, 32'h80FF7F40, 32'h00000007, 32'hFFFF0000, 1'b0},
      '{KSLL, 32'h80FF7F40, 32'h00000008, 32'h80FF7F40, 1'b0},
      '{KSLL, 32'h0001FF00, 32'h00000007, 32'h007F8000, 1'b1},
      '{KSUB, 32'h7F000000, 32'h80000000, 32'h7F000000, 1'b1},
      '{KADD, 32'h40C0C03F, 32'h3F40BF01, 32'h7F008040, 1'b1},
      '{KSRA, 32'h12345678, 32'h00000010, 32'h12345678, 1'b0}
    };

    for (int d = 0; d < ND; d++) begin
      in_valid[d] = 1'b0; srcA[d] = '0; srcB[d] = '0; oper[d] = '0;
      out_ready[d] = 1'b0; vxsat_clr[d] = 1'b0; vx_exp[d] = 1'b0;
    end
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    for (int d = 0; d < ND; d++) begin
      chk1("reset_in_ready", in_ready[d], 1'b1);
      chk1("reset_out_valid", out_valid[d], 1'b0);
      chk("reset_result", result[d], 32'h0);
      chk1("reset_ov", ov[d], 1'b0);
      chk1("reset_vxsat", vxsat[d], 1'b0);
      chk1("reset_zero", zero[d], 1'b1);
    end

    // Table vectors on the default instance; vector 2 also exercises backpressure
    for (int i = 0; i < vt.size(); i++) begin
      issue(0, vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].ovf);
      collect(0, lat_exp[0], (i == 2) ? 5 : 0, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 10; i++) begin
      ra = $urandom(); rb = $urandom(); rop = 2'($urandom_range(0, 3));
      model8(rop, ra, rb, rr, ro);
      issue(0, rop, ra, rb, rr, ro);
      collect(0, lat_exp[0], 0, $sformatf("rnd%0d", i));
    end

    // Clear in IDLE, then clear on the same edge a saturating op enters DONE
    vxsat_clr[0] = 1'b1;
    tick();
    vxsat_clr[0] = 1'b0;
    vx_exp[0] = 1'b0;
    chk1("vxsat_clear", vxsat[0], 1'b0);
    issue(0, KSLL, 32'h7F01C002, 32'h2, 32'h7F048008, 1'b1);
    for (int i = 0; i < lat_exp[0] - 1; i++) tick();
    vxsat_clr[0] = 1'b1;
    tick();
    vxsat_clr[0] = 1'b0;
    chk1("setclr_out_valid", out_valid[0], 1'b1);
    chk1("setclr_vxsat", vxsat[0], 1'b1);
    collect(0, 0, 0, "setclr");

    // Reset mid-BUSY abandons the operation
    issue(0, KADD, 32'h7F7F8080, 32'h01FF80FF, 32'h7F7E8080, 1'b1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb.pop_back());
    for (int d = 0; d < ND; d++) vx_exp[d] = 1'b0;
    chk1("rstbusy_out_valid", out_valid[0], 1'b0);
    chk1("rstbusy_in_ready", in_ready[0], 1'b1);
    chk("rstbusy_result", result[0], 32'h0);
    chk1("rstbusy_vxsat", vxsat[0], 1'b0);
    chk1("rstbusy_ov", ov[0], 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); seen = seen | out_valid[0]; end
    chk1("rstbusy_no_output", seen, 1'b0);

    // Reset wins over a simultaneous request
    in_valid[0] = 1'b1; srcA[0] = 32'h7F7F7F7F; srcB[0] = 32'h01010101; oper[0] = KADD;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid[0] = 1'b0;
    chk1("rst_vs_req_in_ready", in_ready[0], 1'b1);
    tick();
    chk1("rst_vs_req_out_valid", out_valid[0], 1'b0);
    chk1("rst_vs_req_idle", in_ready[0], 1'b1);

    issue(0, vt[0].op, vt[0].a, vt[0].b, vt[0].res, vt[0].ovf);
    collect(0, lat_exp[0], 0, "after_rst");

    // 16-bit lanes
    issue(1, KSRA, 32'h80000010, 32'h00000004, 32'hF8000001, 1'b0);
    collect(1, lat_exp[1], 0, "w16_ksra");
    issue(1, KADD, 32'h7FFF0001, 32'h00017FFF, 32'h7FFF7FFF, 1'b1);
    collect(1, lat_exp[1], 0, "w16_kadd");
    issue(1, KSLL, 32'h0000FFFF, 32'h0000000F, 32'h00008000, 1'b0);
    collect(1, lat_exp[1], 0, "w16_ksll");

    // Four lanes per cycle: single BUSY cycle
    issue(2, KSLL, 32'h7F01C002, 32'h00000002, 32'h7F048008, 1'b1);
    collect(2, lat_exp[2], 0, "lpc4_ksll");
    issue(2, KSUB, 32'h05050505, 32'h01020304, 32'h04030201, 1'b0);
    collect(2, lat_exp[2], 2, "lpc4_ksub");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
